// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch/decode/execute/
// memory/write-back, drives all datapath selects and counts retired instructions.
module multicycle_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ior_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDI   = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  // Moore part of the outputs plus state flags for the mem_ready/zero/opcode-qualified ones.
  typedef struct packed {
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       in_fetch;
    logic       in_decode;
    logic       in_branch;
    logic       in_jump;
  } ctrl_t;

  state_e      state_q, state_d;
  logic [31:0] count_q, count_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        retire;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  function automatic ctrl_t decode_state(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.in_fetch  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.in_decode = 1'b1;
      end
      S_MEMADR, S_ADDI: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_source = 2'b01;
        c.in_branch = 1'b1;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_source = 2'b10;
        c.in_jump   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = S_FETCH;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_R:           state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDI;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        state_d = mem_ready ? S_FETCH : S_MEMWR;
        retire  = mem_ready;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDI:   state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
    count_d = count_q + 32'(retire);
    // Outputs are registered from the next state so they always equal the decode of state_q.
    ctrl_d  = decode_state(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ior_d       = ctrl_q.ior_d;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign reg_dst     = ctrl_q.reg_dst;
  assign reg_write   = ctrl_q.reg_write;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign alu_op      = ctrl_q.alu_op;
  assign pc_source   = ctrl_q.pc_source;
  assign ir_write    = ctrl_q.in_fetch & mem_ready;
  assign illegal_op  = ctrl_q.in_decode & ~op_legal(opcode);
  assign instr_count = count_q;

  // bne inverts the sense of the zero flag for the conditional PC load.
  assign pc_en = (ctrl_q.in_fetch & mem_ready) | ctrl_q.in_jump
               | (ctrl_q.in_branch & (zero ^ (opcode == OP_BNE)));

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized and directed bench for multicycle_control_fsm: each instruction is
// expanded into its expected per-cycle output sequence and compared at negedge.
module tb_multicycle_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, ior_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic        illegal_op;
  logic [31:0] instr_count;

  int          n_assert;
  int          n_fail;
  int unsigned model_cnt;
  logic [15:0] obs;

  multicycle_control_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .ior_d       (ior_d),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .mem_to_reg  (mem_to_reg),
    .reg_dst     (reg_dst),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .pc_source   (pc_source),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  assign obs = {pc_en, ior_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ev(input logic pe, iod, mr, mw, irw, m2r, rd, rw, sa,
                                     input logic [1:0] sb, ao, ps, input logic il);
    return {pe, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, il};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  task automatic check_now(input string tag, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: outputs got %h want %h", tag, obs, exp);
    end
    n_assert++;
    assert (instr_count === model_cnt) else begin
      n_fail++;
      $error("FAIL %s_count: got %0d want %0d", tag, instr_count, model_cnt);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] exp, input logic mr,
                      input logic z, input bit ret);
    mem_ready = mr;
    zero      = z;
    @(negedge clk);
    check_now(tag, exp);
    @(posedge clk);
    #1;
    if (ret) model_cnt++;
  endtask

  // sf/sm = number of not-ready cycles in fetch / data memory access.
  task automatic run_instr(input logic [5:0] op, input logic z, input int sf, input int sm);
    logic r;
    logic taken;
    opcode = op;
    for (int i = 0; i <= sf; i++) begin
      r = (i == sf);
      step("fetch", ev(r,0,1,0,r,0,0,0,0,2'b01,2'b00,2'b00,0), r, rb(), 0);
    end
    step("decode", ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!is_legal(op)), rb(), rb(), 0);
    case (op)
      OP_LW: begin
        step("memadr", ev(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), rb(), rb(), 0);
        for (int i = 0; i <= sm; i++) begin
          r = (i == sm);
          step("memrd", ev(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), r, rb(), 0);
        end
        step("memwb", ev(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), rb(), rb(), 1);
      end
      OP_SW: begin
        step("memadr", ev(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), rb(), rb(), 0);
        for (int i = 0; i <= sm; i++) begin
          r = (i == sm);
          step("memwr", ev(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), r, rb(), r);
        end
      end
      OP_R: begin
        step("exec", ev(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), rb(), rb(), 0);
        step("aluwb", ev(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), rb(), rb(), 1);
      end
      OP_BEQ, OP_BNE: begin
        taken = (op == OP_BEQ) ? z : !z;
        step("branch", ev(taken,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), rb(), z, 1);
      end
      OP_ADDI: begin
        step("addi", ev(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), rb(), rb(), 0);
        step("addiwb", ev(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), rb(), rb(), 1);
      end
      OP_J: step("jump", ev(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), rb(), rb(), 1);
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] op;
    logic [5:0] ops [7];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    n_assert  = 0;
    n_fail    = 0;
    model_cnt = 0;
    reset     = 1'b1;
    opcode    = 6'b0;
    zero      = 1'b0;
    mem_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_now("reset_hold", 16'h0);
    mem_ready = 1'b1;
    opcode    = OP_LW;
    #1;
    check_now("reset_inputs", 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("idle", 16'h0, 1'b1, 1'b0, 0);

    run_instr(OP_LW,   1'b0, 0, 0);
    run_instr(OP_SW,   1'b0, 0, 3);
    run_instr(OP_BEQ,  1'b1, 0, 0);
    run_instr(OP_BEQ,  1'b0, 0, 0);
    run_instr(OP_BNE,  1'b0, 0, 0);
    run_instr(OP_BNE,  1'b1, 0, 0);
    run_instr(OP_R,    1'b0, 0, 0);
    run_instr(OP_ADDI, 1'b0, 0, 0);
    run_instr(6'b111111, 1'b0, 0, 0);
    run_instr(OP_J,    1'b0, 0, 0);
    run_instr(OP_LW,   1'b0, 2, 2);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom_range(0, 63));
        if (is_legal(op)) op = 6'b111111;
      end else begin
        op = ops[$urandom_range(0, 6)];
      end
      run_instr(op, rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // Abandon a lw while it is stalled in the data read.
    opcode = OP_LW;
    step("mr_fetch", ev(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, 1'b0, 0);
    step("mr_decode", ev(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), 1'b0, 1'b0, 0);
    step("mr_memadr", ev(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), 1'b0, 1'b0, 0);
    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_cnt = 0;
    check_now("async_reset", 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("idle2", 16'h0, 1'b1, 1'b0, 0);
    run_instr(OP_J, 1'b0, 0, 0);
    run_instr(OP_R, 1'b0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit for the multi-cycle MIPS core. A Moore state machine that sequences one instruction at a time through fetch, decode, execute, memory and write-back. It drives every datapath select line, including the 2-bit selects of the four-input ALU-B and PC-source multiplexers, plus register, memory and PC write enables. It stalls on a memory-ready handshake and keeps a retired-instruction counter.

## Interface
- No parameters.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; forces S_IDLE and clears counter.
- opcode  input  6  IR[31:26]; IR holds it stable from end of FETCH until next FETCH.
- zero  input  1  ALU zero flag; used only in S_BRANCH.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_en  output  1  PC load enable (see Operation).
- ior_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read, mem_write  output  1 each  memory strobes, held until mem_ready.
- ir_write  output  1  instruction register load.
- mem_to_reg  output  1  write-back data: 0 = ALUOut, 1 = MDR.
- reg_dst  output  1  write register: 0 = rt, 1 = rd.
- reg_write  output  1  register-file write enable.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  ALU-B mux select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate << 2.
- alu_op  output  2  00 = add, 01 = subtract, 10 = funct-decoded.
- pc_source  output  2  PC mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- instr_count  output  32  instructions retired, wraps modulo 2^32.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010. All others are illegal.
- Outputs decode combinationally from the state register only, except pc_en and the mem_ready-qualified enables noted below. Any output not listed for a state is 0.
- S_IDLE: all outputs 0. Next state is S_FETCH unconditionally.
- S_FETCH: mem_read=1, ior_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=mem_ready and pc_write=mem_ready. Stay in S_FETCH while mem_ready=0, else go to S_DECODE.
- S_DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - lw/sw → S_MEMADR
  - R-type → S_EXEC
  - beq/bne → S_BRANCH
  - addi → S_ADDI
  - j → S_JUMP
  - illegal → S_FETCH, with illegal_op=1 for this cycle.
- S_MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw → S_MEMRD, sw → S_MEMWR.
- S_MEMRD: mem_read=1, ior_d=1. Wait for mem_ready, then go to S_MEMWB.
- S_MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Retire, → S_FETCH.
- S_MEMWR: mem_write=1, ior_d=1. Wait for mem_ready, then retire, → S_FETCH.
- S_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → S_ALUWB.
- S_ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Retire, → S_FETCH.
- S_BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1. Retire, → S_FETCH.
- S_ADDI: alu_src_a=1, alu_src_b=10, alu_op=00 → S_ADDIWB.
- S_ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Retire, → S_FETCH.
- S_JUMP: pc_source=10, pc_write=1. Retire, → S_FETCH.
- pc_en = pc_write | (pc_write_cond & (zero ^ (opcode==000101))).
  - beq loads the PC when zero=1; bne loads it when zero=0.
- "Retire" means instr_count increments by 1 on the clock edge leaving that state. Illegal-opcode exits and S_IDLE exits do not retire.
- Unreachable state encodings → S_FETCH on the next edge, all outputs 0 while in them.

## Timing
- Reset (asynchronous assert, synchronous release by clk):
  - state=S_IDLE and instr_count=0 immediately on assert.
  - All outputs read 0 during reset and during the first cycle after release.
  - First S_FETCH is cycle 2 after release.
- Cycle counts with mem_ready always 1:
  - lw 5
  - sw 4, R-type 4, addi 4
  - beq/bne 3, j 3
  - illegal 2
- Each cycle mem_ready=0 in S_FETCH, S_MEMRD or S_MEMWR adds one cycle. Strobes and address select stay constant throughout the stall.
- mem_ready is ignored in every other state.
- Reset asserted mid-instruction: abandon immediately, with no partial retire and no count change other than the clear.
- instr_count 0xFFFFFFFF plus one retire → 0x00000000.

## Test plan
- Reset release, mem_ready=1, opcode=100011 (lw): states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 and mem_to_reg=1 in MEMWB; instr_count=1 after MEMWB.
- sw with mem_ready low for 3 cycles in MEMWR: mem_write=1 and ior_d=1 held for 4 cycles; instr_count increments only once.
- beq with zero=1 → pc_en=1 in BRANCH; beq with zero=0 → pc_en=0; bne with zero=0 → pc_en=1. Each takes 3 cycles.
- R-type: alu_src_b=00 and alu_op=10 in EXEC; reg_dst=1 and reg_write=1 in ALUWB. addi: alu_src_b=10 in ADDI; reg_dst=0 in ADDIWB.
- opcode=111111: illegal_op pulses exactly one cycle in DECODE, returns to FETCH, instr_count unchanged. Then j: pc_source=10, pc_en=1, 3 cycles.
- Reset asserted in MEMRD with mem_ready=0: outputs 0 asynchronously and instr_count=0. After release, FETCH is reached on cycle 2.
